// File: rtl/uart_pkg.sv
// Shared receiver types, baud constants and the parity helper.
// No logic of its own; imported by the receiver and its bench.
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int BPS_CNT       = 434;
  localparam int BPS_HALF      = 217;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Expected parity bit for a zero-extended data word; odd=1 selects odd parity.
  function automatic logic parity_bit(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the idle-high serial line.
// Latency 2 clk; no backpressure.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  // Both flops reset to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by an external mid-bit strobe; parity built only with UART_RX_PARITY_EN.
// Outputs pulse 1 clk after the stop-bit strobe; no backpressure, words are simply overwritten.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 bps_clk,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_s;
  logic                 rx_d;
  logic                 fall;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;

  rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  assign fall = rx_d & ~rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_d       <= 1'b1;
      idx        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      bps_start  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_d       <= rx_s;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        // Edges are only watched here, so one landing on the cycle we return is ignored.
        IDLE: begin
          if (fall) begin
            state     <= START;
            bps_start <= 1'b1;
          end
        end
        START: begin
          if (bps_clk) begin
            if (!rx_s) begin
              state   <= DATA;
              idx     <= '0;
              par_bad <= 1'b0;
            end else begin
              state     <= IDLE;
              bps_start <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bps_clk) begin
            shreg[idx] <= rx_s;
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bps_clk) begin
            par_bad <= (rx_s != parity_bit(32'(shreg), PARITY_ODD));
            state   <= STOP;
          end
        end
        STOP: begin
          if (bps_clk) begin
            bps_start <= 1'b0;
            if (rx_s) begin
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              parity_err <= par_bad;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end
        end
        // A held-low break must see the line high again before re-arming.
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bps_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_BITS, 8, number of data bits per frame, sent LSB first.
REQ-002 Parameter: PARITY_ODD, 0, parity sense when the parity feature is compiled in (0 even, 1 odd).
REQ-003 Port: clk  input  1  system clock, 50 MHz.
REQ-004 Port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 Port: rx  input  1  asynchronous serial line; idles high.
REQ-006 Port: bps_clk  input  1  one-cycle mid-bit sample strobe from the baud generator; 434-clk period, first strobe 217 clks after bps_start rises.
REQ-007 Port: bps_start  output  1  request to the baud generator; its counter runs only while this is high.
REQ-008 Port: rx_data  output  DATA_BITS  last good received word; holds between frames.
REQ-009 Port: rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 Port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 Port: parity_err  output  1  one-cycle pulse on a parity mismatch; tied 0 without UART_RX_PARITY_EN.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rx_s and its 1-cycle-delayed copy.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-014 IDLE: on a falling edge of rx_s, go to START and set bps_start high on the next clk.
REQ-015 bps_start SHALL stay high continuously from START entry until the cycle after the STOP sample, and SHALL be low in IDLE and WAIT_IDLE.
REQ-016 START, on bps_clk: if rx_s=0, go to DATA with bit index 0; if rx_s=1 (glitch), go to IDLE with no output pulse.
REQ-017 DATA, on each bps_clk: shift rx_s into bit[index]. After bit DATA_BITS-1, go to PARITY (macro defined) or STOP.
REQ-018 PARITY, on bps_clk: compare rx_s against the computed parity, latch the result, then go to STOP.
REQ-019 STOP, on bps_clk with rx_s=1: load rx_data and pulse rx_valid on the next clk. Also pulse parity_err in that same cycle if parity mismatched. Then go to IDLE.
REQ-020 STOP, on bps_clk with rx_s=0: pulse frame_err on the next clk, leave rx_data unchanged, suppress rx_valid, and go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL go to IDLE only after rx_s=1 is seen, so a break does not retrigger.
REQ-022 A falling edge that arrives in the same cycle as the IDLE return SHALL NOT start a frame; detection resumes the next cycle.
REQ-023 At most one of rx_valid and frame_err SHALL be high in any cycle.
REQ-024 Back-to-back frames (stop bit immediately followed by a start bit) SHALL be received without loss.

Reset
REQ-025 With rst high at a clk edge, the following SHALL happen on that edge: state to IDLE; bps_start, rx_valid, frame_err and parity_err to 0; rx_data to 0; bit index to 0; both synchronizer flops to 1.
REQ-026 Reset mid-frame SHALL abandon the frame with no output pulse.

Configuration
REQ-027 Macro UART_RX_PARITY_EN SHALL control the parity feature.
REQ-028 With UART_RX_PARITY_EN defined: the frame is start, DATA_BITS data, parity, stop; the PARITY state and the parity_err logic are built.
REQ-029 Without UART_RX_PARITY_EN: the frame is start, DATA_BITS data, stop; the PARITY state is unreachable or removed, parity_err is constant 0, and PARITY_ODD is ignored.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state typedef, the DATA_BITS default, the BPS_CNT=434 and BPS_HALF=217 constants, and the parity helper function.
REQ-031 Sub-module rx_sync (2-flop synchronizer, reset value 1) SHALL be instantiated once.
REQ-032 The baud generator SHALL remain external; uart_rx SHALL only drive bps_start and consume bps_clk.

Verification
REQ-033 The bench SHALL pair uart_rx with a 434/217 baud generator at 50 MHz and drive 4340 clks per 10-bit frame.
REQ-034 Scenario: frame 0x55 -> rx_data=0x55, exactly one rx_valid pulse ~1 clk after the stop sample, bps_start low afterwards.
REQ-035 Scenario: rx low for 100 clks, then high -> no rx_valid or frame_err; bps_start drops after the START sample.
REQ-036 Scenario: frame 0x00 with stop=0, line held low for 20000 clks -> one frame_err, rx_data unchanged, no new frame until rx returns high.
REQ-037 Scenario: back-to-back 0x12, 0x34 -> two rx_valid pulses carrying 0x12 then 0x34.
REQ-038 Scenario: rst asserted in the middle of data bit 4 -> all outputs 0 the next clk; the following 0xA5 frame is received correctly.
REQ-039 Scenario (macro defined, PARITY_ODD=0): 0xA5 sent with parity bit 1 (wrong) -> rx_valid and parity_err pulse in the same cycle, rx_data=0xA5.
